// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the iterative multiply/divide unit:
//     - RV32M/RV64M funct3 encodings (F3_MUL .. F3_REMU)
//     - FSM state encoding (S_IDLE, S_CALC, S_DONE)
//     - helpers telling whether an opcode treats rs1 / rs2 as signed
//   No ports (package).
// ---------------------------------------------------------------------------
package muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // rs1 is interpreted as signed
   function automatic logic f3_a_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   // rs2 is interpreted as signed
   function automatic logic f3_b_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// ---------------------------------------------------------------------------
// muldiv_div_core
//   One combinational restoring-division step on unsigned magnitudes.
//   The partial remainder is shifted left taking in the next dividend bit
//   (MSB of quot_i); if the divisor fits it is subtracted and a 1 enters the
//   quotient, otherwise the shifted remainder is kept and a 0 enters.
//   After XLEN steps starting from rem=0, quot=dividend: quot=quotient,
//   rem=remainder.
// Ports
//   rem_i      in  XLEN  partial remainder
//   quot_i     in  XLEN  dividend bits still to shift in / quotient so far
//   divisor_i  in  XLEN  divisor magnitude
//   rem_o      out XLEN  next partial remainder
//   quot_o     out XLEN  next quotient/dividend shift register
// ---------------------------------------------------------------------------
module muldiv_div_core
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quot_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quot_o
);

   logic [XLEN:0] rem_sh;
   logic [XLEN:0] diff;
   logic          fits;

   always_comb begin
      rem_sh = {rem_i, quot_i[XLEN-1]};
      diff   = rem_sh - {1'b0, divisor_i};
      // rem_i < divisor keeps rem_sh < 2*divisor, so the top bit of the
      // difference is a clean borrow flag.
      fits   = ~diff[XLEN];
      rem_o  = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      quot_o = {quot_i[XLEN-2:0], fits};
   end

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M/RV64M multiply/divide execute unit. Accepts one op via
//   in_valid/in_ready, computes it over XLEN cycles (one bit per cycle),
//   and returns the result via out_valid/out_ready.
//   Handshake: a transfer happens on a rising edge where valid&ready are
//   both high; out_valid and result stay stable until that transfer.
//   Divide corner cases (divide by zero, MIN_INT/-1) skip CALC entirely.
// Configuration
//   FAST_MUL_EN  defined: multiplies use a single-cycle '*' in CALC.
//                undefined (default): multiplies are iterative shift-add.
// Ports
//   clk        in   1     rising-edge clock
//   reset      in   1     synchronous active-high reset
//   flush      in   1     synchronous abort of any op in flight
//   in_valid   in   1     op_a/op_b/funct3 valid
//   in_ready   out  1     unit can accept (IDLE and not in reset)
//   funct3     in   3     MUL..REMU
//   op_a       in   XLEN  rs1 value
//   op_b       in   XLEN  rs2 value
//   out_valid  out  1     result valid, held until out_ready
//   out_ready  in   1     consumer takes result
//   result     out  XLEN  registered result
//   busy       out  1     FSM not in IDLE
// ---------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int              CNT_W   = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic              neg_q, neg_d;        // final result needs negation
   logic [XLEN-1:0]   rem_q, rem_d;        // div: remainder / mul: product high
   logic [XLEN-1:0]   quot_q, quot_d;      // div: quotient  / mul: product low
   logic [XLEN-1:0]   opb_q, opb_d;        // div: divisor   / mul: multiplicand
   logic [XLEN-1:0]   result_q, result_d;
   logic              out_valid_q, out_valid_d;

   // ---------------- accept-side decode ----------------
   logic            a_sign, b_sign;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            in_is_div, b_zero, div_ovf, special;
   logic [XLEN-1:0] special_res;
   logic            neg_in;

   always_comb begin
      a_sign    = op_a[XLEN-1] & f3_a_signed(funct3);
      b_sign    = op_b[XLEN-1] & f3_b_signed(funct3);
      a_mag     = a_sign ? -op_a : op_a;
      b_mag     = b_sign ? -op_b : op_b;
      in_is_div = funct3[2];
      // remainder follows the dividend; everything else follows a^b
      neg_in    = (funct3 == F3_REM) ? a_sign : (a_sign ^ b_sign);
      b_zero    = (op_b == '0);
      div_ovf   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                  (op_a == MIN_INT) && (&op_b);
      special   = in_is_div && (b_zero || div_ovf);
      // funct3[1] selects REM/REMU over DIV/DIVU
      if (b_zero) special_res = funct3[1] ? op_a : '1;
      else        special_res = funct3[1] ? '0   : MIN_INT;
   end

   // ---------------- one iteration step ----------------
   logic            is_div_q;
   logic [XLEN-1:0] div_rem, div_quot;
   logic [XLEN:0]   mul_sum;
   logic [XLEN-1:0] step_hi, step_lo;

   assign is_div_q = f3_q[2];

   muldiv_div_core #(.XLEN(XLEN)) u_div_core (
      .rem_i     (rem_q),
      .quot_i    (quot_q),
      .divisor_i (opb_q),
      .rem_o     (div_rem),
      .quot_o    (div_quot)
   );

   // Shift-add: add multiplicand into the high half when the current
   // multiplier LSB is set, then shift {carry,hi,lo} right by one.
   always_comb begin
      mul_sum = {1'b0, rem_q} + (quot_q[0] ? {1'b0, opb_q} : '0);
      step_hi = is_div_q ? div_rem  : mul_sum[XLEN:1];
      step_lo = is_div_q ? div_quot : {mul_sum[0], quot_q[XLEN-1:1]};
   end

   // ---------------- sign fix-up on the final step ----------------
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, div_res, mul_res;

   always_comb begin
      prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
      quot_fix = neg_q ? -step_lo : step_lo;
      rem_fix  = neg_q ? -step_hi : step_hi;
      div_res  = f3_q[1] ? rem_fix : quot_fix;
   end

`ifdef FAST_MUL_EN
   // Raw operands are latched for multiplies; sign-extending them to the
   // product width gives the same low 2*XLEN bits as an XLEN+1 signed multiply.
   logic                     fa_s, fb_s;
   logic signed [2*XLEN-1:0] fast_a, fast_b, fast_prod;

   always_comb begin
      fa_s      = quot_q[XLEN-1] & f3_a_signed(f3_q);
      fb_s      = opb_q[XLEN-1]  & f3_b_signed(f3_q);
      fast_a    = {{XLEN{fa_s}}, quot_q};
      fast_b    = {{XLEN{fb_s}}, opb_q};
      fast_prod = fast_a * fast_b;
      mul_res   = (f3_q == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
   end
`else
   always_comb begin
      mul_res = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
   end
`endif

   // ---------------- FSM next state ----------------
   logic last_step;

   always_comb begin
`ifdef FAST_MUL_EN
      last_step = !is_div_q || (cnt_q == CNT_W'(XLEN-1));
`else
      last_step = (cnt_q == CNT_W'(XLEN-1));
`endif
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      f3_d        = f3_q;
      neg_d       = neg_q;
      rem_d       = rem_q;
      quot_d      = quot_q;
      opb_d       = opb_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               f3_d  = funct3;
               neg_d = neg_in;
               cnt_d = '0;
               rem_d = '0;
               if (in_is_div) begin
                  quot_d = a_mag;
                  opb_d  = b_mag;
               end else begin
`ifdef FAST_MUL_EN
                  quot_d = op_a;
                  opb_d  = op_b;
`else
                  quot_d = b_mag;   // multiplier, consumed LSB first
                  opb_d  = a_mag;   // multiplicand
`endif
               end
               if (special) begin
                  result_d    = special_res;
                  out_valid_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  state_d     = S_CALC;
               end
            end
         end
         S_CALC: begin
            rem_d  = step_hi;
            quot_d = step_lo;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last_step) begin
               result_d    = is_div_q ? div_res : mul_res;
               out_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase

      // Abort wins over any accept or completion in the same cycle.
      if (flush) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
         cnt_d       = '0;
         result_d    = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         f3_q        <= '0;
         neg_q       <= 1'b0;
         rem_q       <= '0;
         quot_q      <= '0;
         opb_q       <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         f3_q        <= f3_d;
         neg_q       <= neg_d;
         rem_q       <= rem_d;
         quot_q      <= quot_d;
         opb_q       <= opb_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE) && !reset;
   assign busy      = (state_q != S_IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN    = 32;
  localparam int LAT_MAX = 200;
`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      funct3 = 3'd0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            busy;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted output transfer is compared with the oldest
  // expected value; output with nothing expected is an error.
  always @(negedge clk) begin
    #2;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check_eq("unexpected_out", {32'd0, result}, 64'hdead_beef_dead_beef);
      else                   check_eq("result", {32'd0, result}, {32'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] model(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic signed [63:0] sa, sb;
    logic        [63:0] ua, ub, p;
    logic signed [31:0] qa, qb, qr;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    qa  = a;
    qb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      F3_MUL:    begin p = ua * ub; return p[31:0]; end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      F3_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        qr = qa / qb; return qr;
      end
      F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:    begin
        if (b == 0) return a;
        if (ovf)    return 32'd0;
        qr = qa % qb; return qr;
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0) return 1;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Waits for out_valid, counting sample points after the accept edge.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < LAT_MAX) begin
      step();
      lat++;
    end
  endtask

  // Issue one op from IDLE with out_ready high; returns after the handshake.
  task automatic do_op(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp, input int exp_lat);
    int lat;
    check_eq("in_ready_idle", {63'd0, in_ready}, 64'd1);
    funct3   = f3;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    step();
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    funct3   = 3'($urandom_range(0, 7));
    wait_valid(lat);
    check_eq($sformatf("latency_f3_%0d", f3), 64'(lat), 64'(exp_lat));
    step();
  endtask

  // Start an op that will be aborted; nothing is pushed to the scoreboard.
  task automatic start_op(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    funct3   = f3;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int             lat;
    int             seen;
    logic [2:0]     rf3;
    logic [XLEN-1:0] ra, rb;

    // reset state
    repeat (3) step();
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_result",    {32'd0, result},    64'd0);
    check_eq("rst_busy",      {63'd0, busy},      64'd0);
    check_eq("rst_in_ready",  {63'd0, in_ready},  64'd0);
    reset = 1'b0;
    step();
    check_eq("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // directed: multiplies
    do_op(F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    do_op(F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
    do_op(F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    do_op(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    // directed: divides
    do_op(F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT);
    do_op(F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT);
    do_op(F3_DIVU,   32'd100,        32'd7,         32'd14,        DIV_LAT);
    do_op(F3_REMU,   32'd100,        32'd7,         32'd2,         DIV_LAT);
    // special cases
    do_op(F3_DIVU,   32'd100,        32'd0,         32'hFFFF_FFFF, 1);
    do_op(F3_REMU,   32'd100,        32'd0,         32'd100,       1);
    do_op(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
    do_op(F3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    do_op(F3_REM,    32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0, 1);

    // random ops against the model
    for (int i = 0; i < 16; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      do_op(rf3, ra, rb, model(rf3, ra, rb), exp_latency(rf3, ra, rb));
    end

    // output stall: out_ready low 5 cycles in DONE
    out_ready = 1'b0;
    funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7; in_valid = 1'b1;
    exp_q.push_back(32'd14);
    step();
    in_valid = 1'b0;
    wait_valid(lat);
    check_eq("stall_latency", 64'(lat), 64'(DIV_LAT));
    funct3 = F3_MULHU; op_a = 32'd3; op_b = 32'd4; in_valid = 1'b1;  // must be ignored
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("stall_out_valid", {63'd0, out_valid}, 64'd1);
      check_eq("stall_result",    {32'd0, result},    64'd14);
      check_eq("stall_in_ready",  {63'd0, in_ready},  64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check_eq("stall_release_valid", {63'd0, out_valid}, 64'd0);
    check_eq("stall_release_busy",  {63'd0, busy},      64'd0);

    // flush in the middle of CALC
    start_op(F3_DIVU, 32'd1000, 32'd7);
    repeat (9) step();
    check_eq("flush_pre_busy", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_busy",      {63'd0, busy},      64'd0);
    check_eq("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("flush_result",    {32'd0, result},    64'd14);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen++;
    end
    check_eq("flush_no_output", 64'(seen), 64'd0);
    do_op(F3_DIVU, 32'd9, 32'd3, 32'd3, DIV_LAT);

    // flush beats in_valid in the same cycle
    funct3 = F3_DIVU; op_a = 32'd50; op_b = 32'd0; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    check_eq("flush_vs_valid_busy",  {63'd0, busy},      64'd0);
    check_eq("flush_vs_valid_valid", {63'd0, out_valid}, 64'd0);

    // reset in the middle of CALC
    start_op(F3_DIV, 32'hFFFF_FF00, 32'd5);
    repeat (9) step();
    reset = 1'b1;
    #1;
    check_eq("rst_mid_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    check_eq("rst_mid_busy",      {63'd0, busy},      64'd0);
    check_eq("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_mid_result",    {32'd0, result},    64'd0);
    reset = 1'b0;
    step();
    do_op(F3_DIVU, 32'd9, 32'd3, 32'd3, DIV_LAT);
    do_op(F3_MUL,  32'd6, 32'd7, 32'd42, MUL_LAT);

    repeat (5) step();
    check_eq("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
